// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   rx_state_t   - receiver FSM state encoding
//   even_parity  - even-parity bit over a zero-extended data word
package uart_pkg;

   // PARITY is only reachable when the receiver is built with parity support.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   // Widest data word the parity helper accepts. A package function cannot
   // take the receiver's WIDTH parameter, so callers zero-extend their word to
   // this width. Zero padding leaves the XOR unchanged.
   localparam int PARITY_MAX_W = 64;

   // Returns the bit that makes the total number of ones (data + parity) even.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 clk from a pin change to a change on o_q.
// Backpressure: none; it samples every cycle.
//
// Ports:
//   clk      - destination clock
//   i_reset  - asynchronous active-high reset; both flops load RESET_VAL
//   i_d      - asynchronous input
//   o_q      - synchronized output
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic meta;

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         meta <= RESET_VAL;
         o_q  <= RESET_VAL;
      end else begin
         meta <= i_d;
         o_q  <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver that oversamples an 8N1-style line and samples each bit at mid-period.
// Latency: o_dv follows the line's start edge by about 2 + DIVISOR/2 + (WIDTH+1)*DIVISOR clocks.
// Backpressure: none; the consumer must take every o_dv strobe.
//
// Optional build macro: UART_RX_PARITY_EN adds one even-parity bit between
// the data bits and the stop bit. Without it o_parity_err is tied low.
//
// Ports:
//   clk           - system clock
//   i_reset       - asynchronous active-high reset
//   i_rx          - serial line, asynchronous to clk, idle high
//   o_data        - last good word; held until the next good frame
//   o_dv          - one-cycle strobe, o_data valid
//   o_frame_err   - one-cycle strobe, stop bit sampled low
//   o_parity_err  - one-cycle strobe, parity mismatch with a good stop bit
//   o_busy        - high from start-bit detection until the frame ends
//
// DIVISOR must be even and at least 4. WIDTH must be at least 2.
module uart_rx
   import uart_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int DIVISOR = 100
) (
   input  logic             clk,
   input  logic             i_reset,
   input  logic             i_rx,
   output logic [WIDTH-1:0] o_data,
   output logic             o_dv,
   output logic             o_frame_err,
   output logic             o_parity_err,
   output logic             o_busy
);

   localparam int CNT_W = $clog2(DIVISOR);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

`ifdef UART_RX_PARITY_EN
   localparam rx_state_t AFTER_DATA = PARITY;
`else
   localparam rx_state_t AFTER_DATA = STOP;
`endif

   rx_state_t        state;
   rx_state_t        state_nxt;
   logic             rx_s;
   logic [1:0]       fill_cnt;
   logic             line_hi;
   logic             fall;
   logic [CNT_W-1:0] bit_cnt;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] shreg;

   logic             shift_en;
   logic             take_word;
   logic             take_ferr;

   // ------------------------------------------------------------------
   // Line synchronizer and start-edge detector
   // ------------------------------------------------------------------
   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rx_sync (
      .clk     (clk),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rx_s)
   );

   // After reset the synchronizer shows its reset value of 1 for two cycles,
   // whatever the pin is doing. line_hi stays low until that stale value has
   // been flushed. As a result, a line that is already low at reset exit never
   // looks like a falling edge. A start needs a genuinely observed high-to-low
   // transition.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         fill_cnt <= 2'd0;
         line_hi  <= 1'b0;
      end else begin
         if (fill_cnt != 2'd2) begin
            fill_cnt <= fill_cnt + 2'd1;
         end
         line_hi <= (fill_cnt == 2'd2) && rx_s;
      end
   end

   assign fall = line_hi && !rx_s;

   // ------------------------------------------------------------------
   // Receiver FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic                    cap_par;
   logic                    take_perr;
   logic                    par_bad;
   logic [PARITY_MAX_W-1:0] par_ext;

   always_comb begin
      par_ext             = '0;
      par_ext[WIDTH-1:0]  = shreg;
   end
`endif

   // ------------------------------------------------------------------
   // Receiver FSM: next state and per-cycle controls
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      take_word = 1'b0;
      take_ferr = 1'b0;
`ifdef UART_RX_PARITY_EN
      cap_par   = 1'b0;
      take_perr = 1'b0;
`endif

      unique case (state)
         IDLE: begin
            if (fall) begin
               state_nxt = START;
            end
         end

         // Re-check the line half a bit after the edge. A high line here
         // means the edge was noise, so drop it silently.
         START: begin
            if (bit_cnt == CNT_HALF) begin
               state_nxt = rx_s ? IDLE : DATA;
            end
         end

         // This state was entered at mid start bit, so every full count here
         // lands in the middle of a data bit.
         DATA: begin
            if (bit_cnt == CNT_LAST) begin
               shift_en = 1'b1;
               if (idx == IDX_LAST) begin
                  state_nxt = AFTER_DATA;
               end
            end
         end

         PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == CNT_LAST) begin
               cap_par   = 1'b1;
               state_nxt = STOP;
            end
`else
            state_nxt = IDLE;
`endif
         end

         // The stop bit is checked at its midpoint. Going back to IDLE then
         // leaves half a bit of margin before the next start edge.
         STOP: begin
            if (bit_cnt == CNT_LAST) begin
               if (rx_s) begin
                  state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bad) begin
                     take_perr = 1'b1;
                  end else begin
                     take_word = 1'b1;
                  end
`else
                  take_word = 1'b1;
`endif
               end else begin
                  state_nxt = BREAK;
                  take_ferr = 1'b1;
               end
            end
         end

         // A held-low line after a bad stop bit must not look like a string
         // of new frames. Wait for the line to return high first.
         BREAK: begin
            if (rx_s) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Bit-period counter, data index and shift register
   // ------------------------------------------------------------------
   // The counter restarts on every state change, so each state measures its
   // sample point from its own entry. IDLE and BREAK do no timing, so the
   // counter is held at zero there.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         bit_cnt <= '0;
      end else if ((state_nxt != state) || (state == IDLE) ||
                   (state == BREAK) || (bit_cnt == CNT_LAST)) begin
         bit_cnt <= '0;
      end else begin
         bit_cnt <= bit_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         idx <= '0;
      end else if (state != DATA) begin
         idx <= '0;
      end else if (shift_en) begin
         idx <= idx + IDX_W'(1);
      end
   end

   // Bits arrive LSB first. Shifting right from the MSB leaves bit 0 in
   // shreg[0] once all WIDTH bits are in.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         shreg <= '0;
      end else if (shift_en) begin
         shreg <= {rx_s, shreg[WIDTH-1:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         par_bad <= 1'b0;
      end else if (state == IDLE) begin
         par_bad <= 1'b0;
      end else if (cap_par) begin
         par_bad <= rx_s ^ even_parity(par_ext);
      end
   end
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // All strobes come from one STOP decision. That keeps them one cycle wide
   // and mutually exclusive.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         o_data      <= '0;
         o_dv        <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_dv        <= take_word;
         o_frame_err <= take_ferr;
         if (take_word) begin
            o_data <= shreg;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         o_parity_err <= 1'b0;
      end else begin
         o_parity_err <= take_perr;
      end
   end
`else
   assign o_parity_err = 1'b0;
`endif

   assign o_busy = (state != IDLE) && (state != BREAK);

endmodule
